// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ready bus handshake, pipeline stall, load align/extend.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  reg_rd_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  reg_rd_out,
  output logic        fault_out
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        access, fault, accept, timeout;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign access = mem_read_in | mem_write_in;
  assign accept = (state == IDLE) && access && !fault;

  always_comb begin
    fault = 1'b0;
    if (access) begin
      if (mem_read_in && mem_write_in) fault = 1'b1;
      else begin
        case (funct3_in)
          3'b000:  fault = 1'b0;
          3'b001:  fault = alu_result_in[0];
          3'b010:  fault = |alu_result_in[1:0];
          3'b100:  fault = mem_write_in;
          3'b101:  fault = mem_write_in | alu_result_in[0];
          default: fault = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = write_data_in;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << alu_result_in[1:0];
          wdata_d = {4{write_data_in[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << alu_result_in[1:0];
          wdata_d = {2{write_data_in[15:0]}};
        end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= alu_result_in[31:2];
      off_q   <= alu_result_in[1:0];
      f3_q    <= funct3_in;
      we_q    <= mem_write_in;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 to_cnt <= '0;
    else if (accept)                            to_cnt <= '0;
    else if (state == BUSY && !dmem_ready)      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && !dmem_ready && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (dmem_ready || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req       = (state == BUSY);
    dmem_we        = (state == BUSY) && we_q;
    dmem_wstrb     = (state == BUSY) ? wstrb_q : 4'b0000;
    dmem_addr      = {addr_q, 2'b00};
    dmem_wdata     = wdata_q;
    stall          = 1'b0;
    fault_out      = 1'b0;
    reg_write_out  = 1'b0;
    read_data_out  = '0;
    mem_to_reg_out = mem_to_reg_in;
    alu_result_out = alu_result_in;
    reg_rd_out     = reg_rd_in;
    case (state)
      IDLE: begin
        if (fault)       fault_out = 1'b1;
        else if (access) stall = 1'b1;
        else             reg_write_out = reg_write_in;
      end
      BUSY: begin
        if (dmem_ready) begin
          reg_write_out = reg_write_in;
          read_data_out = load_fmt;
        end else if (timeout) fault_out = 1'b1;
        else                  stall = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous; the pipeline-facing controls must drop with it.
    if (!reset) begin
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      dmem_wstrb    = 4'b0000;
      stall         = 1'b0;
      fault_out     = 1'b0;
      reg_write_out = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  reg_rd_in;
  logic        mem_to_reg_in, reg_write_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall, mem_to_reg_out, reg_write_out, fault_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  reg_rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .reg_rd_in(reg_rd_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall(stall), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out), .reg_rd_out(reg_rd_out),
    .fault_out(fault_out)
  );

  task automatic clear_inputs();
    mem_read_in = 0; mem_write_in = 0; funct3_in = 3'b000; alu_result_in = 0;
    write_data_in = 0; reg_rd_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
    dmem_rdata = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    mem_read_in = 1; reg_write_in = 1; funct3_in = 3'b010; alu_result_in = 32'h100;
    #2;
    checks++; if ({dmem_req, dmem_we, dmem_wstrb} !== 6'b0) begin errors++; $display("FAIL reset_bus req/we/wstrb=%b expected 000000", {dmem_req, dmem_we, dmem_wstrb}); end
    checks++; if ({stall, fault_out, reg_write_out} !== 3'b000) begin errors++; $display("FAIL reset_ctl stall/fault/rw=%b expected 000", {stall, fault_out, reg_write_out}); end
    repeat (2) @(posedge clock);
    #1 clear_inputs(); reset = 1;
  endtask

  task automatic test_passthrough(input logic [31:0] alu, input logic [4:0] rd, input string nm);
    @(posedge clock); #1;
    clear_inputs(); alu_result_in = alu; reg_rd_in = rd; reg_write_in = 1;
    @(negedge clock);
    checks++; if ({stall, dmem_req, fault_out, reg_write_out} !== 4'b0001) begin errors++; $display("FAIL %s_ctl stall/req/fault/rw=%b expected 0001", nm, {stall, dmem_req, fault_out, reg_write_out}); end
    checks++; if ({alu_result_out, reg_rd_out, read_data_out} !== {alu, rd, 32'h0}) begin errors++; $display("FAIL %s_data alu=%h rd=%0d rdata=%h expected %h %0d 0", nm, alu_result_out, reg_rd_out, read_data_out, alu, rd); end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] expv, input string nm);
    @(posedge clock); #1;
    clear_inputs(); mem_read_in = 1; funct3_in = f3; alu_result_in = addr;
    reg_write_in = 1; mem_to_reg_in = 1; reg_rd_in = 5'd3;
    @(negedge clock);
    checks++; if ({stall, dmem_req, reg_write_out, fault_out} !== 4'b1000) begin errors++; $display("FAIL %s_accept stall/req/rw/fault=%b expected 1000", nm, {stall, dmem_req, reg_write_out, fault_out}); end
    @(posedge clock); #1;
    dmem_ready = 1; dmem_rdata = rdata;
    @(negedge clock);
    checks++; if ({dmem_req, dmem_we, stall, reg_write_out, mem_to_reg_out} !== 5'b10011) begin errors++; $display("FAIL %s_ready req/we/stall/rw/m2r=%b expected 10011", nm, {dmem_req, dmem_we, stall, reg_write_out, mem_to_reg_out}); end
    checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr got %h expected %h", nm, dmem_addr, {addr[31:2], 2'b00}); end
    checks++; if (read_data_out !== expv) begin errors++; $display("FAIL %s_data got %h expected %h", nm, read_data_out, expv); end
    @(posedge clock); #1 clear_inputs();
    @(negedge clock);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_idle req=%b expected 0", nm, dmem_req); end
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                            input string nm);
    int stall_cnt;
    stall_cnt = 0;
    @(posedge clock); #1;
    clear_inputs(); mem_write_in = 1; funct3_in = f3; alu_result_in = addr; write_data_in = wd;
    @(negedge clock);
    if (stall === 1'b1) stall_cnt++;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clock); #1;
      write_data_in = 32'h5555_5555;
      dmem_ready = (i == waits);
      @(negedge clock);
      if (stall === 1'b1) stall_cnt++;
      checks++; if ({dmem_req, dmem_we, dmem_wstrb} !== {2'b11, exp_strb}) begin errors++; $display("FAIL %s_bus%0d req/we/wstrb=%b expected 11%b", nm, i, {dmem_req, dmem_we, dmem_wstrb}, exp_strb); end
      checks++; if ({dmem_addr, dmem_wdata} !== {addr[31:2], 2'b00, exp_wd}) begin errors++; $display("FAIL %s_addr_data%0d addr=%h wdata=%h expected %h %h", nm, i, dmem_addr, dmem_wdata, {addr[31:2], 2'b00}, exp_wd); end
    end
    checks++; if (stall_cnt != waits + 1) begin errors++; $display("FAIL %s_stall_cycles got %0d expected %0d", nm, stall_cnt, waits + 1); end
    @(posedge clock); #1 clear_inputs();
  endtask

  task automatic test_fault(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input string nm);
    @(posedge clock); #1;
    clear_inputs(); mem_read_in = rd; mem_write_in = wr; funct3_in = f3; alu_result_in = addr;
    reg_write_in = 1;
    @(negedge clock);
    checks++; if ({fault_out, dmem_req, stall, reg_write_out} !== 4'b1000) begin errors++; $display("FAIL %s fault/req/stall/rw=%b expected 1000", nm, {fault_out, dmem_req, stall, reg_write_out}); end
    @(posedge clock); #1 clear_inputs();
    @(negedge clock);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_stay_idle req=%b expected 0", nm, dmem_req); end
  endtask

  task automatic test_reset_busy();
    @(posedge clock); #1;
    clear_inputs(); mem_read_in = 1; funct3_in = 3'b010; alu_result_in = 32'h300; reg_write_in = 1;
    @(posedge clock);
    @(negedge clock);
    checks++; if ({dmem_req, stall} !== 2'b11) begin errors++; $display("FAIL rstbusy_pre req/stall=%b expected 11", {dmem_req, stall}); end
    #2 reset = 0;
    #1;
    checks++; if ({dmem_req, stall, reg_write_out} !== 3'b000) begin errors++; $display("FAIL rstbusy_drop req/stall/rw=%b expected 000", {dmem_req, stall, reg_write_out}); end
    clear_inputs();
    @(posedge clock); #1 reset = 1;
    test_passthrough(32'h42, 5'd5, "add_after_rst");
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1;
    clear_inputs(); mem_read_in = 1; funct3_in = 3'b010; alu_result_in = 32'h400; reg_write_in = 1;
    @(posedge clock); #1 dmem_ready = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clock);
    checks++; if ({dmem_req, stall, read_data_out} !== {2'b10, 32'h1111_2222}) begin errors++; $display("FAIL b2b_first req/stall=%b data=%h expected 10 11112222", {dmem_req, stall}, read_data_out); end
    @(posedge clock); #1 dmem_ready = 0; alu_result_in = 32'h404;
    @(negedge clock);
    checks++; if ({dmem_req, stall, reg_write_out} !== 3'b010) begin errors++; $display("FAIL b2b_reaccept req/stall/rw=%b expected 010", {dmem_req, stall, reg_write_out}); end
    @(posedge clock); #1 dmem_ready = 1; dmem_rdata = 32'h3333_4444;
    @(negedge clock);
    checks++; if ({dmem_addr, read_data_out} !== {32'h404, 32'h3333_4444}) begin errors++; $display("FAIL b2b_second addr=%h data=%h expected 404 33334444", dmem_addr, read_data_out); end
    @(posedge clock); #1 clear_inputs();
  endtask

  task automatic test_timeout();
    @(posedge clock); #1;
    clear_inputs(); mem_read_in = 1; funct3_in = 3'b010; alu_result_in = 32'h500; reg_write_in = 1;
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++; if ({dmem_req, stall, fault_out, reg_write_out} !== ((i == 4) ? 4'b1010 : 4'b1100)) begin errors++; $display("FAIL timeout_busy%0d req/stall/fault/rw=%b", i, {dmem_req, stall, fault_out, reg_write_out}); end
    end
    @(posedge clock); #1 clear_inputs();
    @(negedge clock);
    checks++; if ({dmem_req, fault_out} !== 2'b00) begin errors++; $display("FAIL timeout_idle req/fault=%b expected 00", {dmem_req, fault_out}); end
`else
    repeat (101) @(posedge clock);
    @(negedge clock);
    checks++; if ({dmem_req, stall, fault_out} !== 3'b110) begin errors++; $display("FAIL no_timeout req/stall/fault=%b expected 110", {dmem_req, stall, fault_out}); end
    #1 reset = 0; clear_inputs();
    @(posedge clock); #1 reset = 1;
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough(32'h42, 5'd5, "add");
    test_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, "lw");
    test_load(3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80, "lb");
    test_load(3'b100, 32'h103, 32'h80123456, 32'h00000080, "lbu");
    test_load(3'b101, 32'h102, 32'hBEEF1234, 32'h0000BEEF, "lhu");
    test_load(3'b001, 32'h102, 32'h8001ABCD, 32'hFFFF8001, "lh");
    test_load(3'b000, 32'h100, 32'h0000007F, 32'h0000007F, "lb_pos");
    test_store(3'b000, 32'h201, 32'h000000AB, 3, 4'b0010, 32'hABABABAB, "sb");
    test_store(3'b001, 32'h202, 32'h00001234, 0, 4'b1100, 32'h12341234, "sh");
    test_store(3'b010, 32'h204, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, "sw");
    test_fault(1, 0, 3'b010, 32'h102, "lw_misaligned");
    test_fault(1, 0, 3'b001, 32'h101, "lh_misaligned");
    test_fault(1, 0, 3'b011, 32'h100, "funct3_011");
    test_fault(0, 1, 3'b100, 32'h100, "store_bu");
    test_fault(1, 1, 3'b000, 32'h100, "read_and_write");
    test_back_to_back();
    test_reset_busy();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
